fetch_queue_unit: RTL and testbench

Parametrised instruction-fetch front end for the next-generation miniRISC core. It owns the word-addressed PC, drives the synchronous (1-cycle-latency) instruction ROM, and buffers fetched instructions in a DEPTH-entry queue. Decode consumes the queue through a valid/ready handshake. Branch, jump and branch-register targets arrive on a redirect port that flushes stale work. It replaces the bare PC register + ROM + PC+1 adder path of the single-cycle core, so fetch can run ahead of a stalled back end.

---
 rtl/fetch_queue_unit.sv | 126 ++++++++++++
 tb/tb_fetch_queue_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: instruction-fetch front end for the miniRISC core.
// Owns the word-addressed PC, drives a 1-cycle-latency instruction ROM and
// buffers fetched words in a DEPTH-entry queue that decode drains through a
// valid/ready handshake. A redirect flushes queued and in-flight work and
// fetches the target in the same cycle.
// Optional build macro: FETCH_BYPASS_EN forwards an arriving ROM response
// straight to the outputs when the queue is empty.
module fetch_queue_unit #(
   parameter int ADDR_WIDTH      = 32,
   parameter int INSTR_WIDTH     = 32,
   parameter int IMEM_ADDR_WIDTH = 12,
   parameter int DEPTH           = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   output logic                       imem_en,
   output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
   input  logic [INSTR_WIDTH-1:0]     imem_data,
   input  logic                       redirect_valid,
   input  logic [ADDR_WIDTH-1:0]      redirect_pc,
   output logic                       instr_valid,
   input  logic                       instr_ready,
   output logic [INSTR_WIDTH-1:0]     instr,
   output logic [ADDR_WIDTH-1:0]      instr_pc,
   output logic [ADDR_WIDTH-1:0]      instr_pc_plus1
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [ADDR_WIDTH-1:0] A_ONE = ADDR_WIDTH'(1);
   localparam logic [PW-1:0]         P_ONE = PW'(1);
   localparam logic [CW-1:0]         C_ONE = CW'(1);
   localparam logic [CW:0]           DEPTH_C = (CW+1)'(DEPTH);

   logic [ADDR_WIDTH-1:0]  pc;
   logic                   inflight;
   logic [ADDR_WIDTH-1:0]  inflight_pc;
   logic [INSTR_WIDTH-1:0] q_instr [DEPTH];
   logic [ADDR_WIDTH-1:0]  q_pc    [DEPTH];
   logic [PW-1:0]          rd_ptr;
   logic [PW-1:0]          wr_ptr;
   logic [CW-1:0]          count;

   logic                   q_empty;
   logic                   bypass;
   logic                   pop;
   logic                   q_pop;
   logic                   push;
   logic                   issue;
   logic [CW:0]            occupancy;
   logic [ADDR_WIDTH-1:0]  issue_addr;

   assign q_empty = (count == '0);

`ifdef FETCH_BYPASS_EN
   // An arriving response with nothing queued ahead of it is the head.
   assign bypass = q_empty & inflight;
`else
   assign bypass = 1'b0;
`endif

   assign instr_valid    = ~q_empty | bypass;
   assign instr          = bypass ? imem_data   : q_instr[rd_ptr];
   assign instr_pc       = bypass ? inflight_pc : q_pc[rd_ptr];
   assign instr_pc_plus1 = instr_pc + A_ONE;

   assign pop   = instr_valid & instr_ready;
   assign q_pop = pop & ~bypass;
   // A response is dropped on redirect, and not stored if decode took it directly.
   assign push  = inflight & ~redirect_valid & ~(bypass & instr_ready);

   // Credits: entries already held plus the one in flight, less what leaves now.
   assign occupancy  = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
   assign issue      = ~rst & (redirect_valid | (occupancy < DEPTH_C));
   assign issue_addr = (redirect_valid & ~rst) ? redirect_pc : pc;
   assign imem_en    = issue;
   assign imem_addr  = issue_addr[IMEM_ADDR_WIDTH-1:0];

   // PC, in-flight tracking, queue pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc          <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= RESET_PC;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
      end else begin
         if (issue) begin
            inflight    <= 1'b1;
            inflight_pc <= issue_addr;
            pc          <= issue_addr + A_ONE;
         end else begin
            inflight    <= 1'b0;
         end
         if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (push)  wr_ptr <= wr_ptr + P_ONE;
            if (q_pop) rd_ptr <= rd_ptr + P_ONE;
            case ({push, q_pop})
               2'b10:   count <= count + C_ONE;
               2'b01:   count <= count - C_ONE;
               default: count <= count;
            endcase
         end
      end
   end

   // Queue storage; cleared on reset so idle outputs are never X.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            q_instr[i] <= '0;
            q_pc[i]    <= '0;
         end
      end else if (push) begin
         q_instr[wr_ptr] <= imem_data;
         q_pc[wr_ptr]    <= inflight_pc;
      end
   end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: queue-level reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_fetch_queue_unit;
   localparam int AW = 32, IW = 32, IMW = 12, DEPTH = 4;
`ifdef FETCH_BYPASS_EN
   localparam int LAT = 1;
   localparam bit BYP = 1'b1;
`else
   localparam int LAT = 2;
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic imem_en;
   logic [IMW-1:0] imem_addr;
   logic [IW-1:0] imem_data = '0;
   logic redirect_valid = 1'b0;
   logic [AW-1:0] redirect_pc = '0;
   logic instr_valid;
   logic instr_ready = 1'b0;
   logic [IW-1:0] instr;
   logic [AW-1:0] instr_pc, instr_pc_plus1;

   always #5 clk = ~clk;

   fetch_queue_unit dut (
      .clk(clk), .rst(rst), .imem_en(imem_en), .imem_addr(imem_addr),
      .imem_data(imem_data), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
      .instr_pc_plus1(instr_pc_plus1)
   );

   function automatic logic [IW-1:0] rom(input logic [IMW-1:0] a);
      return 32'h1000_0000 + {20'b0, a};
   endfunction

   always @(posedge clk) if (imem_en === 1'b1) imem_data <= rom(imem_addr);

   int vectors = 0;
   int errs = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // reference model state
   logic [AW-1:0] m_pc, m_ifpc;
   bit            m_if;
   logic [AW-1:0] mq[$];
   int cyc, en_cnt, first_valid_cyc;
   logic [AW-1:0] acc_pc[$], acc_p1[$];
   logic [IW-1:0] acc_instr[$];
   int            acc_cyc[$];

   always @(negedge clk) begin : cmp
      bit ev, byp, pop, en;
      logic [AW-1:0] hp, hp1, addr;
      int occ;
      if (rst) begin
         m_pc = '0; m_if = 1'b0; m_ifpc = '0; mq.delete();
         cyc = 0; en_cnt = 0; first_valid_cyc = -1;
         acc_pc.delete(); acc_p1.delete(); acc_instr.delete(); acc_cyc.delete();
         chk("rst_imem_en", imem_en, 1'b0);
         chk("rst_instr_valid", instr_valid, 1'b0);
         chk("rst_imem_addr", imem_addr, 12'h000);
      end else begin
         byp  = BYP && mq.size() == 0 && m_if;
         ev   = (mq.size() > 0) || byp;
         hp   = byp ? m_ifpc : (mq.size() > 0 ? mq[0] : '0);
         hp1  = hp + 32'd1;
         pop  = ev && instr_ready;
         occ  = mq.size() + int'(m_if) - int'(pop);
         en   = redirect_valid || occ < DEPTH;
         addr = redirect_valid ? redirect_pc : m_pc;
         chk("imem_en", imem_en, en);
         chk("imem_addr", imem_addr, addr[IMW-1:0]);
         chk("instr_valid", instr_valid, ev);
         if (ev) begin
            chk("instr", instr, rom(hp[IMW-1:0]));
            chk("instr_pc", instr_pc, hp);
            chk("instr_pc_plus1", instr_pc_plus1, hp1);
         end
         if (instr_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (instr_valid === 1'b1 && instr_ready) begin
            acc_pc.push_back(instr_pc); acc_p1.push_back(instr_pc_plus1);
            acc_instr.push_back(instr); acc_cyc.push_back(cyc);
         end
         if (imem_en === 1'b1) en_cnt++;
         if (redirect_valid) mq.delete();
         else begin
            if (pop && !byp) void'(mq.pop_front());
            if (m_if && !(byp && instr_ready)) mq.push_back(m_ifpc);
         end
         if (en) begin m_if = 1'b1; m_ifpc = addr; m_pc = addr + 32'd1; end
         else m_if = 1'b0;
         cyc++;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; redirect_valid = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic redirect(input logic [AW-1:0] t, output int rc);
      redirect_valid = 1'b1; redirect_pc = t; rc = cyc;
      tick();
      redirect_valid = 1'b0;
   endtask

   task automatic wait_acc(input int n);
      int b;
      b = 0;
      while (acc_pc.size() < n && b < 200) begin tick(); b++; end
      if (acc_pc.size() < n) chk("wait_acc_timeout", acc_pc.size(), n);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int rc, k, n;
      bit found;

      // 1: reset release, streaming with ready high
      instr_ready = 1'b1;
      do_reset();
      repeat (12) tick();
      chk("first_valid_cycle", first_valid_cyc, LAT);
      for (int i = 0; i < 8; i++) begin
         chk("stream_pc", acc_pc[i], i);
         chk("stream_instr", acc_instr[i], 32'h1000_0000 + i);
         chk("stream_cycle", acc_cyc[i], LAT + i);
         chk("stream_plus1", acc_p1[i], i + 1);
      end

      // 2: ready low from reset, queue fills then drains in order
      instr_ready = 1'b0;
      do_reset();
      repeat (10) tick();
      chk("full_fetch_count", en_cnt, DEPTH);
      chk("full_valid", instr_valid, 1'b1);
      chk("full_head_pc", instr_pc, 32'd0);
      chk("full_imem_en", imem_en, 1'b0);
      instr_ready = 1'b1;
      repeat (12) tick();
      for (int i = 0; i < 8; i++) begin
         chk("drain_pc", acc_pc[i], i);
         chk("drain_nogap", acc_cyc[i] - acc_cyc[0], i);
      end

      // 3: redirect with stalled decode; stale PCs never delivered
      instr_ready = 1'b1;
      do_reset();
      wait_acc(5);
      instr_ready = 1'b0;
      tick(); tick();
      chk("pre_redirect_valid", instr_valid, 1'b1);
      chk("pre_redirect_head", instr_pc, 32'd5);
      redirect(32'h40, rc);
      instr_ready = 1'b1;
      wait_acc(7);
      chk("redir_target", acc_pc[5], 32'h40);
      chk("redir_next", acc_pc[6], 32'h41);
      chk("redir_latency", acc_cyc[5] - rc, LAT);

      // 4: redirect and pop in the same cycle
      do_reset();
      wait_acc(6);
      redirect(32'h80, rc);
      wait_acc(12);
      found = 1'b0; k = 0;
      for (int i = 1; i < acc_cyc.size(); i++)
         if (acc_cyc[i] == rc) begin found = 1'b1; k = i; end
      chk("redir_pop_found", found, 1'b1);
      chk("redir_pop_once", acc_pc[k], acc_pc[k-1] + 32'd1);
      chk("redir_pop_next", acc_pc[k+1], 32'h80);
      chk("redir_pop_next2", acc_pc[k+2], 32'h81);
      chk("redir_pop_latency", acc_cyc[k+1] - rc, LAT);

      // 5: PC wrap at the top of the address space
      do_reset();
      wait_acc(2);
      redirect(32'hFFFF_FFFF, rc);
      n = acc_pc.size() + 6;
      wait_acc(n);
      found = 1'b0; k = 0;
      for (int i = 0; i < acc_pc.size(); i++)
         if (acc_pc[i] == 32'hFFFF_FFFF && !found) begin found = 1'b1; k = i; end
      chk("wrap_found", found, 1'b1);
      chk("wrap_instr", acc_instr[k], 32'h1000_0FFF);
      chk("wrap_plus1", acc_p1[k], 32'd0);
      chk("wrap_next_pc", acc_pc[k+1], 32'd0);

      // 6: asynchronous reset mid-stream with a non-empty queue
      do_reset();
      wait_acc(3);
      instr_ready = 1'b0;
      tick(); tick();
      chk("midrst_pre_valid", instr_valid, 1'b1);
      rst = 1'b1;
      #1;
      chk("midrst_valid", instr_valid, 1'b0);
      chk("midrst_imem_en", imem_en, 1'b0);
      tick();
      instr_ready = 1'b1;
      rst = 1'b0;
      wait_acc(2);
      chk("midrst_first_pc", acc_pc[0], 32'd0);
      chk("midrst_second_pc", acc_pc[1], 32'd1);
      chk("midrst_latency", first_valid_cyc, LAT);

      repeat (3) tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
